// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage feeding the instruction decoder.
// Holds the PC and issues word reads to a synchronous instruction memory
// with one cycle of read latency. Returned words go into a prefetch queue,
// and the queue head is presented to decode over a valid/ready handshake.
// Execute-stage redirects flush the queue and squash the outstanding read.
// Optional feature macro: FETCH_JUMP_PREDECODE_EN. When it is defined, J
// and JAL words are spotted as they return from memory, and fetch steers to
// the jump target without waiting for execute.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  // Architectural state
  logic [31:0]      r_pc;
  logic             r_inflight;
  logic [31:0]      r_inflight_pc;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  entry_t           r_mem [QUEUE_DEPTH];

  // Control wires
  logic             w_push;
  logic             w_pop;
  logic             w_room;
  logic             w_jump;
  logic [31:0]      w_jump_pc;
  logic [31:0]      w_redirect_pc;
  logic [CNT_W-1:0] w_occupancy;

  // The returning word is valid only when a read was issued last cycle.
  // A redirect in this cycle squashes that word together with the queue.
  assign w_push = r_inflight & ~redirect_valid;
  assign w_pop  = instr_valid & instr_ready;

  // Slots already promised to an outstanding read count as used. A pop in
  // the same cycle does not free a slot, which keeps the gating off the
  // decode ready path.
  assign w_occupancy = r_count + {{PTR_W{1'b0}}, r_inflight};
  assign w_room      = w_occupancy < CNT_W'(QUEUE_DEPTH);

  // The two low target bits are dropped, because instructions are word aligned.
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_JUMP_PREDECODE_EN
  // J (6'h02) and JAL (6'h03) are pseudo-direct. The upper four bits come
  // from the address of the slot after the jump.
  assign w_jump    = w_push & ((imem_rdata[31:26] == 6'h02) | (imem_rdata[31:26] == 6'h03));
  assign w_jump_pc = ((r_inflight_pc + 32'd4) & 32'hF000_0000)
                   | {4'b0000, imem_rdata[25:0], 2'b00};
`else
  assign w_jump    = 1'b0;
  assign w_jump_pc = 32'h0000_0000;
`endif

  assign imem_req  = ~rst & ~redirect_valid & ~w_jump & w_room;
  assign imem_addr = r_pc;

  // The head outputs are masked while the queue is empty. Stale storage is never shown.
  assign instr_valid = (r_count != '0);
  assign instr       = instr_valid ? r_mem[r_head].word : 32'h0000_0000;
  assign instr_pc    = instr_valid ? r_mem[r_head].pc   : 32'h0000_0000;

  // PC, in-flight tracking and queue bookkeeping, with reset > redirect > jump > sequential.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every update
    // in this block sees pre-edge values. The order of the statements does not matter.
    if (rst) begin
      r_pc          <= {RESET_PC[31:2], 2'b00};
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0000_0000;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) begin
        r_inflight_pc <= r_pc;
      end

      if (redirect_valid) begin
        r_pc <= w_redirect_pc;
      end else if (w_jump) begin
        r_pc <= w_jump_pc;
      end else if (imem_req) begin
        r_pc <= r_pc + 32'd4;
      end

      if (redirect_valid) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Queue storage write port. The tail slot receives the returning word and its address.
  always_ff @(posedge clk) begin
    // NOTE: queue storage is deliberately not reset. Validity is carried
    // entirely by r_count, so clearing the array would only add reset fan-out.
    if (!rst && w_push) begin
      r_mem[r_tail] <= '{word: imem_rdata, pc: r_inflight_pc};
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit.
// It drives two instances that share their control inputs. Instance "a" uses
// the default RESET_PC, and instance "b" starts at 32'hFFFF_FFF8 to exercise
// PC wrap. Each instance has its own one-cycle-latency memory model. That
// model returns addr>>2, except that 0x10 returns J 0x100 once jump mode is on.
// The expectations for the predecode step follow FETCH_JUMP_PREDECODE_EN.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        jmode;

  logic        imem_req_a, imem_req_b;
  logic [31:0] imem_addr_a, imem_addr_b;
  logic [31:0] imem_rdata_a, imem_rdata_b;
  logic        instr_valid_a, instr_valid_b;
  logic [31:0] instr_a, instr_b;
  logic [31:0] instr_pc_a, instr_pc_b;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(4)) u_dut_a (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req_a),
    .imem_addr      (imem_addr_a),
    .imem_rdata     (imem_rdata_a),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid_a),
    .instr          (instr_a),
    .instr_pc       (instr_pc_a),
    .instr_ready    (instr_ready)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(4)) u_dut_b (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req_b),
    .imem_addr      (imem_addr_b),
    .imem_rdata     (imem_rdata_b),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid_b),
    .instr          (instr_b),
    .instr_pc       (instr_pc_b),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr, input logic jm);
    if (jm && addr == 32'h0000_0010) return 32'h0800_0040;
    return addr >> 2;
  endfunction

  // Synchronous instruction memories. Any cycle without a request returns junk.
  always @(posedge clk) begin
    imem_rdata_a <= imem_req_a ? mem_word(imem_addr_a, jmode) : 32'hDEAD_BEEF;
    imem_rdata_b <= imem_req_b ? mem_word(imem_addr_b, jmode) : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;
    jmode          = 1'b0;

    // Reset state
    tick();
    check("rst_req_a",   {31'b0, imem_req_a},    32'd0);
    check("rst_req_b",   {31'b0, imem_req_b},    32'd0);
    check("rst_valid_a", {31'b0, instr_valid_a}, 32'd0);
    check("rst_instr_a", instr_a,                32'd0);
    check("rst_pc_a",    instr_pc_a,             32'd0);
    tick();
    rst = 1'b0;
    #1;

    // Sequential fetch with decode always ready
    check("c0_req_a",  {31'b0, imem_req_a}, 32'd1);
    check("c0_addr_a", imem_addr_a,         32'h0);
    check("c0_addr_b", imem_addr_b,         32'hFFFF_FFF8);
    tick();
    check("c1_addr_a",  imem_addr_a,            32'h4);
    check("c1_valid_a", {31'b0, instr_valid_a}, 32'd0);
    tick();
    check("c2_valid_a", {31'b0, instr_valid_a}, 32'd1);
    check("c2_pc_a",    instr_pc_a,             32'h0);
    check("c2_instr_a", instr_a,                32'h0);
    check("c2_addr_a",  imem_addr_a,            32'h8);
    check("c2_pc_b",    instr_pc_b,             32'hFFFF_FFF8);
    check("c2_instr_b", instr_b,                32'h3FFF_FFFE);
    tick();
    check("c3_pc_a",    instr_pc_a, 32'h4);
    check("c3_instr_a", instr_a,    32'h1);
    check("c3_pc_b",    instr_pc_b, 32'hFFFF_FFFC);
    tick();
    check("c4_pc_a",    instr_pc_a, 32'h8);
    check("c4_instr_a", instr_a,    32'h2);
    check("c4_pc_b",    instr_pc_b, 32'h0);
    check("c4_instr_b", instr_b,    32'h0);

    // Stall decode. Exactly four words are buffered, and the head stays stable.
    instr_ready = 1'b0;
    repeat (10) tick();
    check("stall_valid", {31'b0, instr_valid_a}, 32'd1);
    check("stall_pc",    instr_pc_a,             32'h8);
    check("stall_instr", instr_a,                32'h2);
    check("stall_req",   {31'b0, imem_req_a},    32'd0);
    instr_ready = 1'b1;
    #1;
    check("release_req_conservative", {31'b0, imem_req_a}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("drain_valid", {31'b0, instr_valid_a}, 32'd1);
      check("drain_pc",    instr_pc_a,             32'h8 + 32'(4 * k));
      check("drain_instr", instr_a,                32'h2 + 32'(k));
    end

    // Build three queued entries plus one read in flight, then redirect.
    instr_ready = 1'b0;
    tick();
    check("pre_redir_pc",  instr_pc_a,          32'h1C);
    check("pre_redir_req", {31'b0, imem_req_a}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    instr_ready    = 1'b1;
    #1;
    check("redir_cycle_req", {31'b0, imem_req_a}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("redir_flush_valid", {31'b0, instr_valid_a}, 32'd0);
    check("redir_req",         {31'b0, imem_req_a},    32'd1);
    check("redir_addr",        imem_addr_a,            32'h100);
    tick();
    check("redir_stale_dropped", {31'b0, instr_valid_a}, 32'd0);
    check("redir_addr_next",     imem_addr_a,            32'h104);
    tick();
    check("redir_first_valid", {31'b0, instr_valid_a}, 32'd1);
    check("redir_first_pc",    instr_pc_a,             32'h100);
    check("redir_first_instr", instr_a,                32'h40);

    // Jump word at 0x10
    jmode          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0008;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("j_addr8", imem_addr_a, 32'h8);
    tick();
    check("j_addrC", imem_addr_a, 32'hC);
    tick();
    check("j_pc8",    instr_pc_a,  32'h8);
    check("j_addr10", imem_addr_a, 32'h10);
    tick();
    check("j_pcC", instr_pc_a, 32'hC);
`ifdef FETCH_JUMP_PREDECODE_EN
    check("j_req_suppressed", {31'b0, imem_req_a}, 32'd0);
`else
    check("j_req_seq",  {31'b0, imem_req_a}, 32'd1);
    check("j_addr_seq", imem_addr_a,         32'h14);
`endif
    tick();
    check("j_word_pc",    instr_pc_a, 32'h10);
    check("j_word_instr", instr_a,    32'h0800_0040);
`ifdef FETCH_JUMP_PREDECODE_EN
    check("j_target_req",  {31'b0, imem_req_a}, 32'd1);
    check("j_target_addr", imem_addr_a,         32'h100);
    tick();
    check("j_gap_valid", {31'b0, instr_valid_a}, 32'd0);
    tick();
    check("j_target_pc",    instr_pc_a, 32'h100);
    check("j_target_instr", instr_a,    32'h40);
`else
    check("j_next_addr", imem_addr_a, 32'h18);
    tick();
    check("j_next_pc",    instr_pc_a, 32'h14);
    check("j_next_instr", instr_a,    32'h5);
    tick();
    check("j_next2_pc", instr_pc_a, 32'h18);
`endif

    // Reset in the middle of a full stall. It wins over a simultaneous redirect.
    instr_ready = 1'b0;
    repeat (8) tick();
    check("full_valid", {31'b0, instr_valid_a}, 32'd1);
    check("full_req",   {31'b0, imem_req_a},    32'd0);
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    check("rst_mid_req", {31'b0, imem_req_a}, 32'd0);
    tick();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("post_rst_valid", {31'b0, instr_valid_a}, 32'd0);
    check("post_rst_instr", instr_a,                32'h0);
    check("post_rst_pc",    instr_pc_a,             32'h0);
    check("post_rst_req",   {31'b0, imem_req_a},    32'd1);
    check("post_rst_addr",  imem_addr_a,            32'h0);
    check("post_rst_addr_b", imem_addr_b,           32'hFFFF_FFF8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
